// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the FullUART receive and transmit paths: the frame
//   FSM state encoding, data-width constants and the parity helper.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Widest character the UART handles; 7-bit mode uses the low bits only.
  localparam int DATA_MAX = 8;

  // Default width of the clocks-per-bit divisor.
  localparam int K_W_DEF = 20;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Parity bit that makes the character valid. Unused high bits must be zero,
  // so the same function serves both 7- and 8-bit characters.
  function automatic logic parity_bit(input logic [DATA_MAX-1:0] data,
                                      input logic            odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Loadable down-counter that paces the serial bit periods.
//
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : (re)start the count this cycle
//   half         : with load, count K/2 (start-bit centring) instead of K
//   k            : clocks per bit; the caller guarantees k >= 2
//   tick         : high for one cycle when the loaded period has elapsed
//
//   A load of P gives tick in the P-th cycle after the load, so an action
//   taken on tick (usually with a fresh load) lands exactly P edges later.
//   Once expired the counter rests at zero and stays quiet until reloaded.
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int K_W = K_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic           half,
  input  logic [K_W-1:0] k,
  output logic           tick
);

  logic [K_W-1:0] cnt;

  // NOTE: clocked state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half ? (k >> 1) : k;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == K_W'(1));

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver. The RX pin is synchronised, start bits are
//   detected and validated at mid-bit, then data, optional parity and the stop
//   bit are sampled at mid-bit using a runtime baud divisor. The finished
//   character is presented with sticky status flags until the host reads it.
//
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   rx       : serial line from the pad buffer, idle high
//   baud_k   : clocks per bit period (values below 2 behave as 2)
//   eight    : 1 = 8 data bits, 0 = 7 data bits
//   pen      : parity enable
//   ohel     : parity select, 1 = odd, 0 = even
//   rd       : one-cycle host read strobe, clears the status flags
//   rx_data  : received byte (bit 7 is 0 in 7-bit mode)
//   rx_rdy   : byte available, sticky until rd
//   perr     : parity error for the byte in rx_data
//   ferr     : framing error (stop bit sampled low)
//   ovf      : a new byte completed while rx_rdy was still set
//
//   Frame configuration is captured when a start edge is accepted, so host
//   writes to the configuration never disturb a frame in flight.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int K_W         = K_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic [K_W-1:0]      baud_k,
  input  logic                eight,
  input  logic                pen,
  input  logic                ohel,
  input  logic                rd,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_rdy,
  output logic                perr,
  output logic                ferr,
  output logic                ovf
);

  // Fewer than two stages would not protect against metastability.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0]   sync_q;
  logic                rxs;

  state_t              state, state_d;

  logic [K_W-1:0]      k_clamp, k_lat, k_sel;
  logic                eight_lat, pen_lat, ohel_lat;

  logic [2:0]          bit_cnt;
  logic [DATA_MAX-1:0] shreg;
  logic                par_bad;

  logic                tick, load, half;
  logic                start_det, shift_en, par_chk, commit;
  logic                last_bit;

  // ---------------------------------------------------------------------------
  // RX synchroniser; resets to the idle-high line level so a reset release
  // can never look like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_N-1];

  // ---------------------------------------------------------------------------
  // Bit timing. The first load happens on the same edge the configuration is
  // captured, so the timer takes the live divisor in IDLE and the captured
  // one for the rest of the frame.
  // ---------------------------------------------------------------------------
  assign k_clamp = (baud_k < K_W'(2)) ? K_W'(2) : baud_k;
  assign k_sel   = (state == IDLE) ? k_clamp : k_lat;

  uart_bit_timer #(.K_W(K_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .half    (half),
    .k       (k_sel),
    .tick    (tick)
  );

  assign last_bit = (bit_cnt == (eight_lat ? 3'd7 : 3'd6));

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state;
    load      = 1'b0;
    half      = 1'b0;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    commit    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxs) begin
          start_det = 1'b1;
          load      = 1'b1;
          half      = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        if (tick) begin
          if (rxs) begin
            // Line already back high at mid start bit: a glitch, drop it.
            state_d = IDLE;
          end else begin
            load    = 1'b1;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          load     = 1'b1;
          if (last_bit) begin
            state_d = pen_lat ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          par_chk = 1'b1;
          load    = 1'b1;
          state_d = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          // No reload: IDLE re-arms on the very next cycle.
          commit  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame datapath: captured configuration, bit counter, character assembly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_lat     <= '0;
      eight_lat <= 1'b0;
      pen_lat   <= 1'b0;
      ohel_lat  <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
    end else begin
      if (start_det) begin
        k_lat     <= k_clamp;
        eight_lat <= eight;
        pen_lat   <= pen;
        ohel_lat  <= ohel;
        bit_cnt   <= '0;
        // Clearing here keeps bit 7 at zero for 7-bit characters.
        shreg     <= '0;
        par_bad   <= 1'b0;
      end
      if (shift_en) begin
        // LSB arrives first, so each sample lands at its bit position.
        shreg[bit_cnt] <= rxs;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (par_chk) begin
        par_bad <= (rxs != parity_bit(shreg, ohel_lat));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host-visible result and status. A commit beats a coincident read: the new
  // byte is flagged ready, and the read still counts as having consumed the
  // previous one, so no overrun is reported.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (commit) begin
      rx_data <= eight_lat ? shreg : {1'b0, shreg[DATA_MAX-2:0]};
      rx_rdy  <= 1'b1;
      perr    <= pen_lat & par_bad;
      ferr    <= ~rxs;
      ovf     <= rx_rdy & ~rd;
    end else if (rd) begin
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed frames driven onto rx. For every frame the bench works out, from
//   the frame format, the byte, flags and the clock at which the byte must
//   appear, and queues that. A model process applies queued results and host
//   reads at the clock edges; a compare process checks every DUT output
//   against it on every falling edge. Literal expectations after selected
//   frames pin the model itself.
//
//   Time origin for latency: the first rising clock edge at which rx is low.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int K_W  = 20;
  localparam int SYNC = 2;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b1;
  logic           rx      = 1'b1;
  logic [K_W-1:0] baud_k  = K_W'(16);
  logic           eight   = 1'b1;
  logic           pen     = 1'b0;
  logic           ohel    = 1'b0;
  logic           rd      = 1'b0;
  logic [7:0]     rx_data;
  logic           rx_rdy;
  logic           perr;
  logic           ferr;
  logic           ovf;

  always #5 clk = ~clk;

  uart_rx #(.K_W(K_W), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .rd      (rd),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc       = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         rise_cyc  = -1;
  int         last_start = 0;
  bit         cmp_on    = 1'b0;
  logic       prev_rdy  = 1'b0;

  logic [7:0] m_data = 8'h00;
  logic       m_rdy  = 1'b0;
  logic       m_perr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: host-visible registers as the receiver should present them.
  // ---------------------------------------------------------------------------
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        // A byte arriving on top of an unread one is an overrun, unless the
        // host reads the old one on this very edge.
        m_ovf  = m_rdy && !rd;
        m_rdy  = 1'b1;
        m_data = exp_q[0].data;
        m_perr = exp_q[0].perr;
        m_ferr = exp_q[0].ferr;
        void'(exp_q.pop_front());
      end else if (rd) begin
        m_rdy  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
      end
    end
  end

  // Compare process: all outputs, every falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("rx_rdy", 32'(rx_rdy), 32'(m_rdy));
      check("rx_data", 32'(rx_data), 32'(m_data));
      check("perr", 32'(perr), 32'(m_perr));
      check("ferr", 32'(ferr), 32'(m_ferr));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (rx_rdy && !prev_rdy) rise_cyc = cyc;
    end
    prev_rdy = rx_rdy;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_clear();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rd_clears_rdy", 32'(rx_rdy), 32'd0);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    baud_k = K_W'(16);
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    rx     = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  // Drive one frame. abort_bit >= 0 pulls reset in the middle of that data
  // bit; scramble flips the configuration inputs mid-frame.
  task automatic send_frame(input logic [7:0] data, input int k_raw,
                            input logic e8, input logic p_en, input logic odd,
                            input logic par_bit, input logic stop_bit,
                            input bit rd_commit, input int abort_bit,
                            input bit scramble);
    int         k, n, t, c0, commit_cyc, ones;
    logic [11:0] bits;
    logic [7:0] mask;
    logic       good_par;
    bit         aborted;
    exp_t       e;

    k    = (k_raw < 2) ? 2 : k_raw;
    n    = e8 ? 8 : 7;
    t    = 2 + n + (p_en ? 1 : 0);
    mask = e8 ? 8'hFF : 8'h7F;

    bits    = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < n; j++) bits[1 + j] = data[j];
    if (p_en) bits[1 + n] = par_bit;
    bits[t - 1] = stop_bit;

    ones     = $countones(data & mask);
    good_par = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    e.data   = data & mask;
    e.perr   = p_en && (par_bit != good_par);
    e.ferr   = !stop_bit;
    aborted  = 1'b0;

    @(negedge clk);
    baud_k = K_W'(k_raw);
    eight  = e8;
    pen    = p_en;
    ohel   = odd;
    c0     = cyc;
    last_start = c0 + 1;
    commit_cyc = c0 + 1 + SYNC + k / 2 + (t - 1) * k;
    e.cyc  = commit_cyc;
    if (abort_bit < 0) exp_q.push_back(e);

    for (int i = 0; i < t * k; i++) begin
      if (i > 0) @(negedge clk);
      rx = bits[i / k];
      rd = rd_commit && (cyc == commit_cyc - 1);
      if (scramble && i == 2 * k) begin
        baud_k = K_W'(3);
        eight  = ~e8;
        pen    = ~p_en;
        ohel   = ~odd;
      end
      if (abort_bit >= 0 && i == (abort_bit + 1) * k + k / 2) begin
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rdy", 32'(rx_rdy), 32'd0);
        check("async_rst_data", 32'(rx_data), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      @(negedge clk);
      rx = 1'b1;
      rd = 1'b0;
    end
    baud_k = K_W'(k_raw);
    eight  = e8;
    pen    = p_en;
    ohel   = odd;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    #1 reset_n = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rx_rdy), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_flags", 32'({perr, ferr, ovf}), 32'd0);
    reset_n = 1'b1;
    idle(5);

    // 8N1, K=16, 0x55
    send_frame(8'h55, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("latency_k16_8n1", 32'(rise_cyc - last_start), 32'd154);
    check("data_55", 32'(rx_data), 32'h55);
    check("flags_55", 32'({perr, ferr, ovf}), 32'd0);
    read_clear();
    idle(4);

    // 8E1, 0xA3: correct parity is 0
    send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    check("data_a3", 32'(rx_data), 32'hA3);
    check("perr_a3_bad", 32'(perr), 32'd1);
    check("ferr_a3", 32'(ferr), 32'd0);
    read_clear();
    send_frame(8'hA3, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("perr_a3_good", 32'(perr), 32'd0);
    read_clear();

    // 7O1, 0x7F with parity 0, then with a bad stop bit
    send_frame(8'h7F, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("data_7f", 32'(rx_data), 32'h7F);
    check("perr_7f", 32'(perr), 32'd0);
    read_clear();
    send_frame(8'h7F, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    check("ferr_7f", 32'(ferr), 32'd1);
    read_clear();
    idle(40);

    // Start glitch, then a clean 0x12
    glitch(3);
    idle(40);
    check("glitch_no_rdy", 32'(rx_rdy), 32'd0);
    send_frame(8'h12, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("data_12", 32'(rx_data), 32'h12);
    read_clear();

    // Overrun, then a read coinciding with the commit
    send_frame(8'h01, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'h02, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("ovr_data_02", 32'(rx_data), 32'h02);
    check("ovr_ovf", 32'(ovf), 32'd1);
    send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check("coll_rdy", 32'(rx_rdy), 32'd1);
    check("coll_ovf", 32'(ovf), 32'd0);
    check("coll_data", 32'(rx_data), 32'h03);

    // Reset during data bit 4 (rx_rdy still set from 0x03), then 0xC6
    send_frame(8'h9A, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    idle(5);
    send_frame(8'hC6, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    check("data_c6", 32'(rx_data), 32'hC6);
    check("ovf_c6", 32'(ovf), 32'd0);
    read_clear();

    // Configuration changed mid-frame must not affect it: 8O1, K=5, 0xB4
    send_frame(8'hB4, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b1);
    idle(4);
    check("data_b4", 32'(rx_data), 32'hB4);
    check("perr_b4", 32'(perr), 32'd0);
    read_clear();

    // Divisor below 2 behaves as 2
    send_frame(8'h81, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    idle(6);
    check("latency_k1", 32'(rise_cyc - last_start), 32'd21);
    check("data_81", 32'(rx_data), 32'h81);
    read_clear();
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, stuck at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
